// File: rtl/cellrv32_npu_package.sv
// Shared NPU types: instruction layout, opcode map, opcode classes, activation functions
// and the decoder state type.
package cellrv32_npu_package;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_SYNC        = 8'h01;
    localparam logic [7:0] OP_LOAD_WEIGHT = 8'h08;
    localparam logic [7:0] OP_MATMUL      = 8'h20;
    localparam logic [3:0] OP_ACTIVATE_HI = 4'h4;
    localparam logic [3:0] ACT_FUNC_MAX   = 4'd10;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] calc_len;
        logic [15:0] acc_addr;
        logic [23:0] buff_addr;
    } instruction_t;

    typedef struct packed {
        logic [31:0] calc_len;
        logic [39:0] weight_addr;
    } weight_instruction_t;

    typedef enum logic [3:0] {
        ACT_NONE     = 4'd0,
        ACT_RELU     = 4'd1,
        ACT_RELU6    = 4'd2,
        ACT_CRELU    = 4'd3,
        ACT_ELU      = 4'd4,
        ACT_SELU     = 4'd5,
        ACT_SOFTPLUS = 4'd6,
        ACT_SOFTSIGN = 4'd7,
        ACT_DROPOUT  = 4'd8,
        ACT_SIGMOID  = 4'd9,
        ACT_TANH     = 4'd10
    } activation_type_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_SYNC,
        CLS_WEIGHT,
        CLS_MATMUL,
        CLS_ACT,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WEIGHT,
        ST_MATMUL,
        ST_ACT,
        ST_SYNC
    } state_t;

    // Weight memory is addressed by the buffer and accumulator fields joined into one 40-bit word.
    function automatic weight_instruction_t to_weight_instruction(input instruction_t ins);
        weight_instruction_t w;
        w.calc_len    = ins.calc_len;
        w.weight_addr = {ins.buff_addr, ins.acc_addr};
        return w;
    endfunction

    function automatic op_class_t decode_class(input logic [7:0] opcode);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_NOP:         cls = CLS_NOP;
            OP_SYNC:        cls = CLS_SYNC;
            OP_LOAD_WEIGHT: cls = CLS_WEIGHT;
            OP_MATMUL:      cls = CLS_MATMUL;
            default: begin
                if (opcode[7:4] == OP_ACTIVATE_HI && opcode[3:0] <= ACT_FUNC_MAX)
                    cls = CLS_ACT;
            end
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cellrv32_npu_instr_decoder_if.sv
// Instruction, beat-stream and status signals of the NPU instruction decoder.
interface cellrv32_npu_instr_decoder_if;
    import cellrv32_npu_package::*;

    logic             instr_valid_i;
    logic             instr_ready_o;
    instruction_t     instr_i;

    logic             wei_valid_o;
    logic             wei_ready_i;
    logic [39:0]      wei_addr_o;

    logic             mm_valid_o;
    logic             mm_ready_i;
    logic [23:0]      mm_buff_addr_o;
    logic [15:0]      mm_acc_addr_o;
    logic             mm_first_o;

    logic             act_valid_o;
    logic             act_ready_i;
    logic [15:0]      act_acc_addr_o;
    logic [23:0]      act_buff_addr_o;
    activation_type_t act_func_o;

    logic             units_idle_i;
    logic             busy_o;
    logic             illegal_o;
    logic             illegal_clr_i;

    modport slave (
        input  instr_valid_i, instr_i, wei_ready_i, mm_ready_i, act_ready_i,
               units_idle_i, illegal_clr_i,
        output instr_ready_o, wei_valid_o, wei_addr_o,
               mm_valid_o, mm_buff_addr_o, mm_acc_addr_o, mm_first_o,
               act_valid_o, act_acc_addr_o, act_buff_addr_o, act_func_o,
               busy_o, illegal_o
    );

    modport master (
        output instr_valid_i, instr_i, wei_ready_i, mm_ready_i, act_ready_i,
               units_idle_i, illegal_clr_i,
        input  instr_ready_o, wei_valid_o, wei_addr_o,
               mm_valid_o, mm_buff_addr_o, mm_acc_addr_o, mm_first_o,
               act_valid_o, act_acc_addr_o, act_buff_addr_o, act_func_o,
               busy_o, illegal_o
    );

endinterface

// File: rtl/cellrv32_npu_beat_counter.sv
// Beat sequencer: holds the base address and a remaining-beat down-counter; the address steps
// either as one 40-bit word or as independent 24-bit buffer / 16-bit accumulator fields.
module cellrv32_npu_beat_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        split,
    input  logic [39:0] base,
    input  logic [31:0] len,
    input  logic        advance,
    output logic [39:0] addr,
    output logic        first,
    output logic        last
);

    logic [31:0] remaining;
    logic        split_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr      <= '0;
            remaining <= '0;
            first     <= 1'b0;
            split_q   <= 1'b0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
            first     <= 1'b1;
            split_q   <= split;
        end else if (advance && remaining != 32'd0) begin
            remaining <= remaining - 32'd1;
            first     <= 1'b0;
            addr      <= split_q ? {addr[39:16] + 24'd1, addr[15:0] + 16'd1} : addr + 40'd1;
        end
    end

    assign last = (remaining == 32'd1);

endmodule

// File: rtl/cellrv32_npu_instr_decoder.sv
// NPU instruction decoder: turns packed instructions into weight/matmul/activation beat streams.
// Defining CELLRV32_NPU_DECODER_SKID_EN adds a one-entry holding register for zero-bubble issue.
module cellrv32_npu_instr_decoder
    import cellrv32_npu_package::*;
(
    input  logic clk_i,
    input  logic rst_i,
    cellrv32_npu_instr_decoder_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for an instruction
    // WEIGHT | issuing weight-load beats
    // MATMUL | issuing matrix-multiply beats
    // ACT    | issuing activation beats
    // SYNC   | waiting for downstream units to drain

    state_t              state;
    logic                wei_valid;
    logic                mm_valid;
    logic                act_valid;
    logic                illegal;
    activation_type_t    act_func;
    logic                held;
    instruction_t        held_instr;

    logic                instr_fire;
    logic                beat_fire;
    logic                finishing;
    logic                start;
    instruction_t        start_instr;
    op_class_t           start_cls;
    weight_instruction_t winstr;
    logic                has_beats;
    logic                cnt_load;
    logic                cnt_split;
    logic                cnt_first;
    logic                cnt_last;
    logic [39:0]         cnt_base;
    logic [39:0]         cnt_addr;
    logic [31:0]         cnt_len;

    assign instr_fire = bus.instr_valid_i & bus.instr_ready_o;
    assign beat_fire  = (wei_valid & bus.wei_ready_i) | (mm_valid & bus.mm_ready_i)
                      | (act_valid & bus.act_ready_i);
    assign finishing  = (beat_fire & cnt_last) | ((state == ST_SYNC) & bus.units_idle_i);

    // A new instruction starts from IDLE, or back-to-back as the current one finishes.
    assign start       = (instr_fire & ((state == ST_IDLE) | finishing)) | (finishing & held);
    assign start_instr = held ? held_instr : bus.instr_i;
    assign start_cls   = decode_class(start_instr.opcode);
    assign winstr      = to_weight_instruction(start_instr);
    assign has_beats   = (start_instr.calc_len != 32'd0);
    assign cnt_load    = start & has_beats & (start_cls inside {CLS_WEIGHT, CLS_MATMUL, CLS_ACT});
    assign cnt_split   = (start_cls != CLS_WEIGHT);
    assign cnt_base    = cnt_split ? {start_instr.buff_addr, start_instr.acc_addr} : winstr.weight_addr;
    assign cnt_len     = cnt_split ? start_instr.calc_len : winstr.calc_len;

`ifdef CELLRV32_NPU_DECODER_SKID_EN
    logic hold_load;

    assign hold_load         = instr_fire & (state != ST_IDLE) & ~finishing;
    assign bus.instr_ready_o = ~held;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held       <= 1'b0;
            held_instr <= '0;
        end else if (hold_load) begin
            held       <= 1'b1;
            held_instr <= bus.instr_i;
        end else if (start & held) begin
            held       <= 1'b0;
        end
    end
`else
    assign held              = 1'b0;
    assign held_instr        = '0;
    assign bus.instr_ready_o = (state == ST_IDLE);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            wei_valid <= 1'b0;
            mm_valid  <= 1'b0;
            act_valid <= 1'b0;
            act_func  <= ACT_NONE;
            illegal   <= 1'b0;
        end else begin
            if (start) begin
                wei_valid <= cnt_load & (start_cls == CLS_WEIGHT);
                mm_valid  <= cnt_load & (start_cls == CLS_MATMUL);
                act_valid <= cnt_load & (start_cls == CLS_ACT);
                case (start_cls)
                    CLS_WEIGHT: state <= has_beats ? ST_WEIGHT : ST_IDLE;
                    CLS_MATMUL: state <= has_beats ? ST_MATMUL : ST_IDLE;
                    CLS_ACT: begin
                        state    <= has_beats ? ST_ACT : ST_IDLE;
                        act_func <= activation_type_t'(start_instr.opcode[3:0]);
                    end
                    CLS_SYNC:   state <= ST_SYNC;
                    default:    state <= ST_IDLE;
                endcase
            end else if (finishing) begin
                state     <= ST_IDLE;
                wei_valid <= 1'b0;
                mm_valid  <= 1'b0;
                act_valid <= 1'b0;
            end

            if (start & (start_cls == CLS_ILLEGAL))
                illegal <= 1'b1;
            else if (bus.illegal_clr_i)
                illegal <= 1'b0;
        end
    end

    cellrv32_npu_beat_counter u_beat_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (cnt_load),
        .split   (cnt_split),
        .base    (cnt_base),
        .len     (cnt_len),
        .advance (beat_fire),
        .addr    (cnt_addr),
        .first   (cnt_first),
        .last    (cnt_last)
    );

    assign bus.wei_valid_o     = wei_valid;
    assign bus.wei_addr_o      = cnt_addr;
    assign bus.mm_valid_o      = mm_valid;
    assign bus.mm_buff_addr_o  = cnt_addr[39:16];
    assign bus.mm_acc_addr_o   = cnt_addr[15:0];
    assign bus.mm_first_o      = cnt_first;
    assign bus.act_valid_o     = act_valid;
    assign bus.act_buff_addr_o = cnt_addr[39:16];
    assign bus.act_acc_addr_o  = cnt_addr[15:0];
    assign bus.act_func_o      = act_func;
    assign bus.busy_o          = (state != ST_IDLE) | held;
    assign bus.illegal_o       = illegal;

endmodule

// File: tb/tb_cellrv32_npu_instr_decoder.sv
// Directed-vector bench for the NPU instruction decoder; covers the skid build when
// CELLRV32_NPU_DECODER_SKID_EN is defined.
module tb_cellrv32_npu_instr_decoder;
    import cellrv32_npu_package::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    cellrv32_npu_instr_decoder_if bus();

    cellrv32_npu_instr_decoder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (32'(bus.wei_valid_o) + 32'(bus.mm_valid_o) + 32'(bus.act_valid_o) > 32'd1) begin
                miscompares++;
                $display("FAIL valid_onehot: got wei=%b mm=%b act=%b, want at most one high",
                         bus.wei_valid_o, bus.mm_valid_o, bus.act_valid_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic instruction_t mk(input logic [7:0] op, input logic [31:0] len,
                                        input logic [15:0] acc, input logic [23:0] buff);
        instruction_t i;
        i.opcode    = op;
        i.calc_len  = len;
        i.acc_addr  = acc;
        i.buff_addr = buff;
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input instruction_t ins);
        int n;
        n = 0;
        bus.instr_i       = ins;
        bus.instr_valid_i = 1'b1;
        while (bus.instr_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL send_timeout: got instr_ready_o=%b after %0d cycles, want 1", bus.instr_ready_o, n);
        end
        tick();
        bus.instr_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.wei_ready_i   = 1'b1;
        bus.mm_ready_i    = 1'b1;
        bus.act_ready_i   = 1'b1;
        bus.units_idle_i  = 1'b1;
        bus.illegal_clr_i = 1'b0;
        rst = 1'b1;
        #2;
        vectors++;
        if ({bus.instr_ready_o, bus.busy_o, bus.illegal_o, bus.wei_valid_o, bus.mm_valid_o, bus.act_valid_o} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_status: got rdy/busy/ill/wv/mv/av=%b, want 100000",
                     {bus.instr_ready_o, bus.busy_o, bus.illegal_o, bus.wei_valid_o, bus.mm_valid_o, bus.act_valid_o});
        end
        vectors++;
        if (bus.wei_addr_o !== 40'h0 || bus.mm_first_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: got addr=%h first=%b, want 0 0", bus.wei_addr_o, bus.mm_first_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mm_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%b busy=%b mv=%b, want 1 0 0",
                     bus.instr_ready_o, bus.busy_o, bus.mm_valid_o);
        end
    endtask

    task automatic test_matmul();
        logic [23:0] eb;
        logic [15:0] ea;
        send(mk(OP_MATMUL, 32'd3, 16'h0020, 24'h000010));
        for (int k = 0; k < 3; k++) begin
            eb = 24'h000010 + 24'(k);
            ea = 16'h0020 + 16'(k);
            vectors++;
            if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== eb || bus.mm_acc_addr_o !== ea
                || bus.mm_first_o !== (k == 0) || bus.busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL matmul_beat%0d: got v=%b buff=%h acc=%h first=%b busy=%b, want 1 %h %h %b 1",
                         k, bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_acc_addr_o, bus.mm_first_o, bus.busy_o,
                         eb, ea, (k == 0));
            end
            tick();
        end
        vectors++;
        if (bus.mm_valid_o !== 1'b0 || bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL matmul_end: got v=%b rdy=%b busy=%b, want 0 1 0",
                     bus.mm_valid_o, bus.instr_ready_o, bus.busy_o);
        end
        // split fields wrap independently
        send(mk(OP_MATMUL, 32'd2, 16'h0010, 24'hFFFFFF));
        vectors++;
        if (bus.mm_buff_addr_o !== 24'hFFFFFF || bus.mm_acc_addr_o !== 16'h0010) begin
            miscompares++;
            $display("FAIL matmul_wrap0: got buff=%h acc=%h, want ffffff 0010", bus.mm_buff_addr_o, bus.mm_acc_addr_o);
        end
        tick();
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000000 || bus.mm_acc_addr_o !== 16'h0011) begin
            miscompares++;
            $display("FAIL matmul_wrap1: got v=%b buff=%h acc=%h, want 1 000000 0011",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_acc_addr_o);
        end
        tick();
    endtask

    task automatic test_weight();
        bus.wei_ready_i = 1'b0;
        send(mk(OP_LOAD_WEIGHT, 32'd2, 16'h1234, 24'hABCDEF));
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.wei_valid_o !== 1'b1 || bus.wei_addr_o !== 40'hABCDEF1234) begin
                miscompares++;
                $display("FAIL weight_stall%0d: got v=%b addr=%h, want 1 abcdef1234", c, bus.wei_valid_o, bus.wei_addr_o);
            end
            if (c < 2) tick();
        end
        bus.wei_ready_i = 1'b1;
        tick();
        vectors++;
        if (bus.wei_valid_o !== 1'b1 || bus.wei_addr_o !== 40'hABCDEF1235) begin
            miscompares++;
            $display("FAIL weight_beat1: got v=%b addr=%h, want 1 abcdef1235", bus.wei_valid_o, bus.wei_addr_o);
        end
        tick();
        vectors++;
        if (bus.wei_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL weight_end: got v=%b busy=%b, want 0 0", bus.wei_valid_o, bus.busy_o);
        end
        send(mk(OP_LOAD_WEIGHT, 32'd2, 16'hFFFF, 24'hFFFFFF));
        tick();
        vectors++;
        if (bus.wei_valid_o !== 1'b1 || bus.wei_addr_o !== 40'h0000000000) begin
            miscompares++;
            $display("FAIL weight_wrap: got v=%b addr=%h, want 1 0000000000", bus.wei_valid_o, bus.wei_addr_o);
        end
        tick();
    endtask

    task automatic test_activate();
        send(mk(8'h49, 32'd2, 16'hFFFF, 24'h000100));
        vectors++;
        if (bus.act_valid_o !== 1'b1 || bus.act_func_o !== 4'd9 || bus.act_acc_addr_o !== 16'hFFFF
            || bus.act_buff_addr_o !== 24'h000100) begin
            miscompares++;
            $display("FAIL act_beat0: got v=%b func=%0d acc=%h buff=%h, want 1 9 ffff 000100",
                     bus.act_valid_o, bus.act_func_o, bus.act_acc_addr_o, bus.act_buff_addr_o);
        end
        tick();
        vectors++;
        if (bus.act_valid_o !== 1'b1 || bus.act_acc_addr_o !== 16'h0000 || bus.act_buff_addr_o !== 24'h000101) begin
            miscompares++;
            $display("FAIL act_beat1: got v=%b acc=%h buff=%h, want 1 0000 000101",
                     bus.act_valid_o, bus.act_acc_addr_o, bus.act_buff_addr_o);
        end
        tick();
        send(mk(8'h4A, 32'd1, 16'h0007, 24'h000003));
        vectors++;
        if (bus.act_valid_o !== 1'b1 || bus.act_func_o !== 4'd10 || bus.illegal_o !== 1'b0) begin
            miscompares++;
            $display("FAIL act_max_func: got v=%b func=%0d ill=%b, want 1 10 0",
                     bus.act_valid_o, bus.act_func_o, bus.illegal_o);
        end
        tick();
        vectors++;
        if (bus.act_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL act_end: got v=%b, want 0", bus.act_valid_o);
        end
    endtask

    task automatic test_illegal();
        send(mk(8'h4F, 32'd3, 16'h0001, 24'h000001));
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.illegal_o !== 1'b1 || bus.act_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_4f_c%0d: got ill=%b av=%b busy=%b, want 1 0 0",
                         c, bus.illegal_o, bus.act_valid_o, bus.busy_o);
            end
            tick();
        end
        bus.illegal_clr_i = 1'b1;
        tick();
        bus.illegal_clr_i = 1'b0;
        vectors++;
        if (bus.illegal_o !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: got ill=%b, want 0", bus.illegal_o);
        end
        bus.illegal_clr_i = 1'b1;
        send(mk(8'h77, 32'd4, 16'h0000, 24'h000000));
        bus.illegal_clr_i = 1'b0;
        vectors++;
        if (bus.illegal_o !== 1'b1 || bus.mm_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_set_wins: got ill=%b mv=%b, want 1 0", bus.illegal_o, bus.mm_valid_o);
        end
        bus.illegal_clr_i = 1'b1;
        tick();
        bus.illegal_clr_i = 1'b0;
        send(mk(OP_NOP, 32'd5, 16'h0001, 24'h000001));
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({bus.wei_valid_o, bus.mm_valid_o, bus.act_valid_o, bus.busy_o, bus.illegal_o} !== 5'b0) begin
                miscompares++;
                $display("FAIL nop_c%0d: got wv/mv/av/busy/ill=%b, want 00000",
                         c, {bus.wei_valid_o, bus.mm_valid_o, bus.act_valid_o, bus.busy_o, bus.illegal_o});
            end
            tick();
        end
        send(mk(OP_MATMUL, 32'd0, 16'h0001, 24'h000001));
        vectors++;
        if (bus.mm_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.illegal_o !== 1'b0) begin
            miscompares++;
            $display("FAIL matmul_len0: got mv=%b busy=%b ill=%b, want 0 0 0", bus.mm_valid_o, bus.busy_o, bus.illegal_o);
        end
    endtask

    task automatic test_sync();
        logic exp_ready;
`ifdef CELLRV32_NPU_DECODER_SKID_EN
        exp_ready = 1'b1;
`else
        exp_ready = 1'b0;
`endif
        bus.units_idle_i = 1'b0;
        send(mk(OP_SYNC, 32'd0, 16'h0000, 24'h000000));
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (bus.busy_o !== 1'b1 || bus.instr_ready_o !== exp_ready || bus.mm_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL sync_wait%0d: got busy=%b rdy=%b mv=%b, want 1 %b 0",
                         c, bus.busy_o, bus.instr_ready_o, bus.mm_valid_o, exp_ready);
            end
            tick();
        end
        bus.units_idle_i = 1'b1;
        tick();
        vectors++;
        if (bus.busy_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_done: got busy=%b rdy=%b, want 0 1", bus.busy_o, bus.instr_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        send(mk(OP_MATMUL, 32'd10, 16'h0000, 24'h000000));
        tick();
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000001) begin
            miscompares++;
            $display("FAIL rstmid_beat1: got mv=%b buff=%h, want 1 000001", bus.mm_valid_o, bus.mm_buff_addr_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.mm_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.instr_ready_o !== 1'b1
            || bus.mm_buff_addr_o !== 24'h0) begin
            miscompares++;
            $display("FAIL rstmid_async: got mv=%b busy=%b rdy=%b buff=%h, want 0 0 1 000000",
                     bus.mm_valid_o, bus.busy_o, bus.instr_ready_o, bus.mm_buff_addr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus.mm_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_quiet%0d: got mv=%b, want 0", c, bus.mm_valid_o);
            end
        end
        send(mk(OP_MATMUL, 32'd1, 16'h0066, 24'h000055));
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000055 || bus.mm_acc_addr_o !== 16'h0066
            || bus.mm_first_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_recover: got mv=%b buff=%h acc=%h first=%b, want 1 000055 0066 1",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_acc_addr_o, bus.mm_first_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        send(mk(OP_MATMUL, 32'd2, 16'h0200, 24'h000100));
        bus.instr_i       = mk(OP_MATMUL, 32'd2, 16'h0400, 24'h000300);
        bus.instr_valid_i = 1'b1;
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000100 || bus.mm_first_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_a0: got mv=%b buff=%h first=%b, want 1 000100 1",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_first_o);
        end
        tick();
`ifdef CELLRV32_NPU_DECODER_SKID_EN
        bus.instr_valid_i = 1'b0;
        vectors++;
        if (bus.instr_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_held: got rdy=%b busy=%b, want 0 1", bus.instr_ready_o, bus.busy_o);
        end
`endif
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000101 || bus.mm_first_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_a1: got mv=%b buff=%h first=%b, want 1 000101 0",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_first_o);
        end
        tick();
`ifndef CELLRV32_NPU_DECODER_SKID_EN
        vectors++;
        if (bus.mm_valid_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_bubble: got mv=%b rdy=%b, want 0 1", bus.mm_valid_o, bus.instr_ready_o);
        end
        tick();
        bus.instr_valid_i = 1'b0;
`endif
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000300 || bus.mm_acc_addr_o !== 16'h0400
            || bus.mm_first_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_b0: got mv=%b buff=%h acc=%h first=%b, want 1 000300 0400 1",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_acc_addr_o, bus.mm_first_o);
        end
        tick();
        vectors++;
        if (bus.mm_valid_o !== 1'b1 || bus.mm_buff_addr_o !== 24'h000301 || bus.mm_acc_addr_o !== 16'h0401
            || bus.mm_first_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_b1: got mv=%b buff=%h acc=%h first=%b, want 1 000301 0401 0",
                     bus.mm_valid_o, bus.mm_buff_addr_o, bus.mm_acc_addr_o, bus.mm_first_o);
        end
        tick();
        vectors++;
        if (bus.mm_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got mv=%b busy=%b, want 0 0", bus.mm_valid_o, bus.busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_weight();
        test_activate();
        test_illegal();
        test_sync();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cellrv32_npu_instr_decoder.md
CELLRV32_NPU_INSTR_DECODER -- requirements
Module: cellrv32_npu_instr_decoder

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have instr_valid_i / instr_ready_o, in/out, 1 each, instruction handshake; transfer occurs when both are high on a clock edge.
REQ-004 SHALL have instr_i, input, 80, packed instruction_t: opcode[79:72], calc_len[71:40], acc_addr[39:24], buff_addr[23:0].
REQ-005 SHALL have wei_valid_o / wei_ready_i, out/in, 1 each, weight-load beat handshake; wei_addr_o, out, 40, weight address.
REQ-006 SHALL have mm_valid_o / mm_ready_i, out/in, 1 each, matrix-multiply beat handshake; mm_buff_addr_o 24, mm_acc_addr_o 16, mm_first_o 1 (first beat of the instruction).
REQ-007 SHALL have act_valid_o / act_ready_i, out/in, 1 each, activation beat handshake; act_acc_addr_o 16, act_buff_addr_o 24, act_func_o 4 (activation_type_t).
REQ-008 SHALL have units_idle_i, input, 1, downstream units drained; busy_o, output, 1; illegal_o, output, 1, sticky illegal-opcode flag; illegal_clr_i, input, 1.

Function
REQ-009 Opcode map SHALL be: 0x00 NOP, 0x01 SYNC, 0x08 LOAD_WEIGHT, 0x20 MATMUL, 0x4N ACTIVATE with N = opcode[3:0]; any other value is illegal.
REQ-010 FSM states SHALL be IDLE, WEIGHT, MATMUL, ACT, SYNC; reset state IDLE.
REQ-011 In IDLE, instr_ready_o SHALL be 1; an accepted instruction is latched and decoded in the same edge.
REQ-012 NOP, an illegal opcode, or calc_len = 0 on LOAD_WEIGHT/MATMUL/ACTIVATE SHALL stay in IDLE and issue no beats.
REQ-013 Illegal opcode, or ACTIVATE with N > 10, SHALL set illegal_o on the next edge; illegal_o clears only on illegal_clr_i (set wins if simultaneous).
REQ-014 LOAD_WEIGHT SHALL enter WEIGHT; the weight address is {buff_addr, acc_addr} (to_weight_instruction); beat k drives wei_addr_o = base + k.
REQ-015 MATMUL SHALL enter MATMUL; beat k drives buff_addr+k and acc_addr+k; mm_first_o = 1 only on beat 0.
REQ-016 ACTIVATE SHALL enter ACT; beat k drives acc_addr+k, buff_addr+k, and act_func_o = N.
REQ-017 First beat valid SHALL assert the cycle after acceptance; a beat advances only on valid&ready; valid and payload SHALL hold stable while ready is low.
REQ-018 Exactly calc_len beats SHALL issue; after the last beat transfers, FSM returns to IDLE (one bubble cycle between instructions).
REQ-019 Address increments SHALL wrap modulo field width (24, 16, 40 bits) without flags.
REQ-020 SYNC SHALL wait until units_idle_i = 1, then return to IDLE; no beats issued.
REQ-021 At most one of wei_valid_o, mm_valid_o, act_valid_o SHALL be high in any cycle.
REQ-022 busy_o SHALL be 1 whenever FSM is not IDLE or a held instruction exists.

Reset
REQ-023 rst_i SHALL immediately force IDLE, all valid outputs 0, busy_o 0, illegal_o 0, address/length registers 0, skid buffer empty; instr_ready_o is 1 after reset.
REQ-024 Reset mid-instruction SHALL abandon remaining beats; no beat issues until a new instruction is accepted.

Configuration
REQ-025 Macro CELLRV32_NPU_DECODER_SKID_EN SHALL, when defined, add a one-entry input holding register: instr_ready_o = !held, one instruction is accepted while beats issue, and the held instruction starts the cycle after the last beat (zero-bubble).
REQ-026 Without CELLRV32_NPU_DECODER_SKID_EN, instr_ready_o SHALL equal (state == IDLE); behaviour per REQ-018.

Structure
REQ-027 Opcode constants, the opcode-class enum, and the FSM state type SHALL live in cellrv32_npu_package; instruction_t, to_weight_instruction, and activation_type_t are reused.
REQ-028 Beat sequencing (base, length, counter, done) SHALL be one sub-module, cellrv32_npu_beat_counter, instantiated once.

Verification
REQ-029 MATMUL, calc_len=3, buff=0x000010, acc=0x0020, ready always 1 -> 3 beats on consecutive cycles (0x10/0x20, 0x11/0x21, 0x12/0x22), mm_first_o only on the first, then IDLE.
REQ-030 LOAD_WEIGHT, buff=0xABCDEF, acc=0x1234, calc_len=2, wei_ready_i low for 2 cycles -> wei_addr_o holds 0xABCDEF1234 stable, then 0xABCDEF1235 issues.
REQ-031 ACTIVATE opcode 0x49, acc=0xFFFF, calc_len=2 -> act_func_o = 9 (SIGMOID), acc addresses 0xFFFF then 0x0000.
REQ-032 Opcode 0x4F and 0x77 -> no beats, illegal_o = 1 until illegal_clr_i pulse; NOP with calc_len=5 -> no beats.
REQ-033 SYNC with units_idle_i = 0 for 4 cycles -> busy_o = 1, instr_ready_o = 0 (no skid), then IDLE one cycle after units_idle_i = 1.
REQ-034 rst_i asserted after beat 1 of a 10-beat MATMUL -> mm_valid_o = 0 immediately, no further beats; with SKID_EN, two back-to-back MATMULs show no gap cycle.
